// File: rtl/route_ctrl.sv
// route_ctrl: 5-port router control - round-robin header arbiter,
// XY routing and crossbar table. Macro ROUTE_WEST_FIRST_EN: west-first adaptive.
`ifndef EAST
`define EAST 0
`endif
`ifndef WEST
`define WEST 1
`endif
`ifndef NORTH
`define NORTH 2
`endif
`ifndef SOUTH
`define SOUTH 3
`endif
`ifndef LOCAL
`define LOCAL 4
`endif

module route_ctrl #(
  parameter int COORD_W = 8,
  parameter logic [2*COORD_W-1:0] ADDRESS = '0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [4:0]               h,
  input  logic [5*2*COORD_W-1:0]   dest,
  input  logic [4:0]               sender,
  output logic [4:0]               ack_h,
  output logic [14:0]              mux_in,
  output logic [4:0]               enable_out
);
  localparam int NPORT = 5;
  localparam logic [2:0] P_E = 3'(`EAST);
  localparam logic [2:0] P_W = 3'(`WEST);
  localparam logic [2:0] P_N = 3'(`NORTH);
  localparam logic [2:0] P_S = 3'(`SOUTH);
  localparam logic [2:0] P_L = 3'(`LOCAL);

  typedef enum logic [1:0] {
    S_IDLE, S_ARB, S_ROUTE, S_GRANT
  } state_t;

  state_t state, state_n;
  logic [2:0] sel, last_sel, req_port;
  logic [2:0] arb_idx, xy_port, route_port;
  logic [3:0] cand;
  logic       arb_hit, grant;
  logic [2*COORD_W-1:0] cur_dest;
  logic [COORD_W-1:0] dx, dy, lx, ly;
  logic [7:0] h_x, en_x, snd_x;
  logic [4:0] en_n;
  logic [14:0] mux_n;

  assign lx    = ADDRESS[2*COORD_W-1:COORD_W];
  assign ly    = ADDRESS[COORD_W-1:0];
  assign dx    = cur_dest[2*COORD_W-1:COORD_W];
  assign dy    = cur_dest[COORD_W-1:0];
  assign h_x   = {3'b000, h};
  assign en_x  = {3'b000, enable_out};
  assign snd_x = {3'b000, sender};

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // FSM next state: one phase per cycle, abandon if headers vanish
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (|h) state_n = S_ARB;
      S_ARB:   state_n = arb_hit ? S_ROUTE : S_IDLE;
      S_ROUTE: state_n = S_GRANT;
      S_GRANT: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Round-robin search starting just after the last winner
  always_comb begin
    arb_idx = sel;
    arb_hit = 1'b0;
    cand    = '0;
    for (int k = 1; k <= NPORT; k++) begin
      cand = {1'b0, last_sel} + 4'(k);
      if (cand >= 4'(NPORT)) cand = cand - 4'(NPORT);
      if (!arb_hit && h_x[cand[2:0]]) begin
        arb_hit = 1'b1;
        arb_idx = cand[2:0];
      end
    end
  end

  // Header target of the selected input
  always_comb begin
    cur_dest = '0;
    for (int i = 0; i < NPORT; i++)
      if (sel == 3'(i)) cur_dest = dest[i*2*COORD_W +: 2*COORD_W];
  end

  // Output port choice: XY, optionally west-first over free ports
  always_comb begin
    if (dx > lx)      xy_port = P_E;
    else if (dx < lx) xy_port = P_W;
    else if (dy < ly) xy_port = P_S;
    else if (dy > ly) xy_port = P_N;
    else              xy_port = P_L;
    route_port = xy_port;
`ifdef ROUTE_WEST_FIRST_EN
    if (dx >= lx) begin
      if (dx > lx && !enable_out[`EAST])
        route_port = P_E;
      else if (dy > ly && !enable_out[`NORTH])
        route_port = P_N;
      else if (dy < ly && !enable_out[`SOUTH])
        route_port = P_S;
    end
`endif
  end

  // Grant only to a still-pending header on a registered-free output
  assign grant = (state == S_GRANT) && h_x[sel]
               && !en_x[req_port] && !reset;
  assign ack_h = grant ? (5'b00001 << sel) : 5'b00000;

  // Crossbar table: drop finished connections, add the new grant
  always_comb begin
    en_n  = '0;
    mux_n = mux_in;
    for (int o = 0; o < NPORT; o++) begin
      en_n[o] = enable_out[o] && snd_x[mux_in[o*3 +: 3]];
      if (grant && req_port == 3'(o)) begin
        en_n[o]         = 1'b1;
        mux_n[o*3 +: 3] = sel;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      sel        <= '0;
      last_sel   <= 3'(NPORT - 1);
      req_port   <= '0;
      enable_out <= '0;
      mux_in     <= '0;
    end else begin
      if (state == S_ARB && arb_hit) begin
        sel      <= arb_idx;
        last_sel <= arb_idx;
      end
      if (state == S_ROUTE) req_port <= route_port;
      enable_out <= en_n;
      mux_in     <= mux_n;
    end
  end

endmodule
